// File: rtl/register_unit.sv
// register_unit: RV32I integer register file with two combinational read ports, a registered debug read port and a write counter
// Ports:
//   i_clk, i_rst_n                    clock, synchronous active-low reset
//   i_rs1_addr/i_rs2_addr             read addresses -> o_rs1_data/o_rs2_data (combinational)
//   i_rd_addr, i_wb_data, i_wr_en     write port, committed on the rising edge
//   i_dbg_addr, i_dbg_req             debug read request -> o_dbg_data/o_dbg_valid (one cycle later)
//   o_wr_count                        count of committed writes to x1..x(NREGS-1)
module register_unit #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter logic [XLEN-1:0] SP_INIT = 32'h0000_03FC,
  parameter bit BYPASS = 1'b0,
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       i_rs1_addr,
  input  logic [4:0]       i_rs2_addr,
  input  logic [4:0]       i_rd_addr,
  input  logic [XLEN-1:0]  i_wb_data,
  input  logic             i_wr_en,
  output logic [XLEN-1:0]  o_rs1_data,
  output logic [XLEN-1:0]  o_rs2_data,
  input  logic [4:0]       i_dbg_addr,
  input  logic             i_dbg_req,
  output logic [XLEN-1:0]  o_dbg_data,
  output logic             o_dbg_valid,
  output logic [CNT_W-1:0] o_wr_count
);
  logic [XLEN-1:0]  r_regs [1:NREGS-1];
  logic [XLEN-1:0]  r_dbg_data;
  logic             r_dbg_valid;
  logic [CNT_W-1:0] r_wr_count;
  logic             w_wr;
  // Matching only x1..x(NREGS-1) makes x0 and out-of-range addresses read 0
  function automatic logic [XLEN-1:0] rd_reg(input logic [4:0] a);
    rd_reg = '0;
    for (int i = 1; i < NREGS; i++) rd_reg = (a == 5'(i)) ? r_regs[i] : rd_reg;
  endfunction
  always_comb begin
    w_wr = 1'b0;
    for (int i = 1; i < NREGS; i++) w_wr = w_wr | (i_wr_en && i_rd_addr == 5'(i));
  end
  assign o_rs1_data = (BYPASS && w_wr && i_rs1_addr == i_rd_addr) ? i_wb_data : rd_reg(i_rs1_addr);
  assign o_rs2_data = (BYPASS && w_wr && i_rs2_addr == i_rd_addr) ? i_wb_data : rd_reg(i_rs2_addr);
  assign o_dbg_data = r_dbg_data;
  assign o_dbg_valid = r_dbg_valid;
  assign o_wr_count = r_wr_count;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 1; i < NREGS; i++) r_regs[i] <= (i == 2) ? SP_INIT : '0;
      r_dbg_data <= '0;
      r_dbg_valid <= 1'b0;
      r_wr_count <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) if (w_wr && i_rd_addr == 5'(i)) r_regs[i] <= i_wb_data;
      if (w_wr) r_wr_count <= r_wr_count + CNT_W'(1);
      if (i_dbg_req) r_dbg_data <= rd_reg(i_dbg_addr);
      r_dbg_valid <= i_dbg_req;
    end
  end
endmodule
